// File: rtl/store_req_unit_pkg.sv
// Shared constants and types for the data-memory issue unit.
package store_req_unit_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    localparam int DEF_MAX_OUTSTANDING = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } sru_state_t;

endpackage

// File: rtl/store_req_unit_lane_gen.sv
// Byte-strobe / lane-replicated write-data generation and alignment check.
module store_lane_gen
    import store_req_unit_pkg::*;
(
    input  logic [1:0]  op_size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic        is_store_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_rep_o,
    output logic        misalign_o
);

    always_comb begin
        wstrb_o     = 4'b0000;
        wdata_rep_o = 32'h0;
        misalign_o  = 1'b0;
        case (op_size_i)
            MEM_SIZE_B: begin
                wstrb_o     = 4'b0001 << addr_lo_i;
                wdata_rep_o = {4{wdata_i[7:0]}};
            end
            MEM_SIZE_H: begin
                wstrb_o     = 4'b0011 << addr_lo_i;
                wdata_rep_o = {2{wdata_i[15:0]}};
                misalign_o  = addr_lo_i[0];
            end
            // 2'b11 falls through here and behaves as a word access
            default: begin
                wstrb_o     = 4'b1111;
                wdata_rep_o = wdata_i;
                misalign_o  = (addr_lo_i != 2'b00);
            end
        endcase
        if (!is_store_i) begin
            wstrb_o     = 4'b0000;
            wdata_rep_o = 32'h0;
        end
    end

endmodule

// File: rtl/store_req_unit.sv
// Issues one load/store micro-op onto the SRAM-like data bus and tracks
// how many issued requests still await their data_ok response.
module store_req_unit
    import store_req_unit_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int CNT_W           = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_is_store,
    input  logic [1:0]  op_size,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    output logic        ade,
    output logic [31:0] ade_addr,
    output logic        busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    sru_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ade_q, ade_d;
    logic [31:0]       ade_addr_q, ade_addr_d;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [31:0]       addr_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;

    logic [3:0]        gen_wstrb;
    logic [31:0]       gen_wdata;
    logic              gen_misalign;
    logic              accept, issue, inc, dec;

    store_lane_gen u_lane_gen (
        .op_size_i   (op_size),
        .addr_lo_i   (op_addr[1:0]),
        .wdata_i     (op_wdata),
        .is_store_i  (op_is_store),
        .wstrb_o     (gen_wstrb),
        .wdata_rep_o (gen_wdata),
        .misalign_o  (gen_misalign)
    );

    assign op_ready = (state_q == ST_IDLE) && (cnt_q < MAX_CNT);
    assign accept   = op_valid && op_ready;
    assign issue    = accept && !gen_misalign;

    // A response arriving with nothing outstanding is dropped, not counted.
    assign inc = (state_q == ST_REQ) && data_addr_ok;
    assign dec = data_data_ok && (cnt_q != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ade_d      = accept && gen_misalign;
        ade_addr_d = ade_addr_q;
        if (accept && gen_misalign)
            ade_addr_d = op_addr;
        case (state_q)
            ST_IDLE: if (issue)        state_d = ST_REQ;
            ST_REQ:  if (data_addr_ok) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
        if (inc && !dec)
            cnt_d = cnt_q + CNT_ONE;
        else if (!inc && dec)
            cnt_d = cnt_q - CNT_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ade_q      <= 1'b0;
            ade_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ade_q      <= ade_d;
            ade_addr_q <= ade_addr_d;
        end
    end

    // Bus fields are captured only on issue, so they stay frozen through REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wstrb_q <= 4'b0000;
            wdata_q <= 32'h0;
        end else if (issue) begin
            wr_q    <= op_is_store;
            size_q  <= op_size;
            addr_q  <= op_addr;
            wstrb_q <= gen_wstrb;
            wdata_q <= gen_wdata;
        end
    end

    assign data_req   = (state_q == ST_REQ);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wstrb = wstrb_q;
    assign data_wdata = wdata_q;
    assign ade        = ade_q;
    assign ade_addr   = ade_addr_q;
    assign busy       = (state_q == ST_REQ) || (cnt_q != '0);

endmodule

// File: tb/tb_store_req_unit.sv
// Directed bench for store_req_unit with hand-computed expectations.
module tb_store_req_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid, op_ready, op_is_store;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic        ade;
    logic [31:0] ade_addr;
    logic        busy;

    int total = 0;
    int bad   = 0;

    store_req_unit #(.MAX_OUTSTANDING(2), .CNT_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_is_store  (op_is_store),
        .op_size      (op_size),
        .op_addr      (op_addr),
        .op_wdata     (op_wdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .ade          (ade),
        .ade_addr     (ade_addr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic st, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        op_valid = 1'b1; op_is_store = st; op_size = sz; op_addr = a; op_wdata = d;
    endtask

    initial begin
        reset = 1'b1;
        op_valid = 1'b0; op_is_store = 1'b0; op_size = 2'b00; op_addr = 32'h0; op_wdata = 32'h0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #3;
        chk("rst_data_req", data_req, 0);
        chk("rst_ade", ade, 0);
        chk("rst_ade_addr", ade_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wstrb", data_wstrb, 0);
        @(negedge clk); reset = 1'b0;
        step();
        chk("idle_ready", op_ready, 1);

        // sb to 0x1000_0003, addr_ok in the first request cycle
        offer(1'b1, 2'b00, 32'h1000_0003, 32'h0000_00A5);
        #1 chk("sb_ready", op_ready, 1);
        step();
        op_valid = 1'b0; data_addr_ok = 1'b1;
        #1;
        chk("sb_req", data_req, 1);
        chk("sb_wr", data_wr, 1);
        chk("sb_wstrb", data_wstrb, 32'h8);
        chk("sb_wdata", data_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", data_addr, 32'h1000_0003);
        chk("sb_ready_req", op_ready, 0);
        step();
        data_addr_ok = 1'b0;
        chk("sb_req_drop", data_req, 0);
        chk("sb_busy_cnt1", busy, 1);
        chk("sb_ready_cnt1", op_ready, 1);
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        chk("sb_busy_done", busy, 0);

        // sh to 0x2002, addr_ok delayed 3 cycles
        offer(1'b1, 2'b01, 32'h0000_2002, 32'h0000_1234);
        step();
        op_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("sh_req_hold", data_req, 1);
            chk("sh_wstrb", data_wstrb, 32'hC);
            chk("sh_wdata", data_wdata, 32'h1234_1234);
            chk("sh_size", data_size, 1);
            chk("sh_ready", op_ready, 0);
            step();
        end
        data_addr_ok = 1'b1;
        #1;
        chk("sh_req_last", data_req, 1);
        chk("sh_addr_last", data_addr, 32'h2002);
        step();
        data_addr_ok = 1'b0;
        chk("sh_req_drop", data_req, 0);
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        chk("sh_busy_done", busy, 0);

        // misaligned lw 0x3001
        offer(1'b0, 2'b10, 32'h0000_3001, 32'h0);
        #1 chk("ade_ready", op_ready, 1);
        step();
        op_valid = 1'b0;
        chk("ade_noreq", data_req, 0);
        chk("ade_pulse", ade, 1);
        chk("ade_addr", ade_addr, 32'h3001);
        chk("ade_ready_after", op_ready, 1);
        chk("ade_busy", busy, 0);
        step();
        chk("ade_pulse_end", ade, 0);
        chk("ade_addr_hold", ade_addr, 32'h3001);

        // aligned lw: no strobes, no write data
        offer(1'b0, 2'b11, 32'h0000_4000, 32'hDEAD_BEEF);
        step();
        op_valid = 1'b0; data_addr_ok = 1'b1;
        #1;
        chk("lw_req", data_req, 1);
        chk("lw_wr", data_wr, 0);
        chk("lw_wstrb", data_wstrb, 0);
        chk("lw_wdata", data_wdata, 0);
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        chk("lw_busy_done", busy, 0);

        // three back-to-back stores, backpressure at count 2
        offer(1'b1, 2'b10, 32'h0000_0100, 32'h1111_1111);
        step();
        op_valid = 1'b0; data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        offer(1'b1, 2'b10, 32'h0000_0104, 32'h2222_2222);
        #1 chk("bp_ready_cnt1", op_ready, 1);
        step();
        op_valid = 1'b0; data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        offer(1'b1, 2'b10, 32'h0000_0108, 32'h3333_3333);
        #1 chk("bp_ready_cnt2", op_ready, 0);
        step();
        chk("bp_noreq", data_req, 0);
        chk("bp_ready_hold", op_ready, 0);
        data_data_ok = 1'b1;
        #1 chk("bp_ready_same_cycle", op_ready, 0);
        step();
        data_data_ok = 1'b0;
        chk("bp_ready_resume", op_ready, 1);
        step();
        op_valid = 1'b0;
        chk("bp_third_req", data_req, 1);
        chk("bp_third_addr", data_addr, 32'h108);

        // addr_ok and data_ok together at count 1: count stays 1
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        chk("both_busy", busy, 1);
        chk("both_ready", op_ready, 1);
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        chk("both_drain", busy, 0);

        // spurious data_ok at count 0
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        chk("spur_busy", busy, 0);
        chk("spur_ready", op_ready, 1);

        // async reset while a request is on the bus
        offer(1'b1, 2'b00, 32'h0000_5001, 32'h0000_0077);
        step();
        op_valid = 1'b0;
        chk("ar_req_before", data_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_req", data_req, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ade", ade, 0);
        @(negedge clk); reset = 1'b0;
        step();
        chk("ar_ready", op_ready, 1);
        chk("ar_req_after", data_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_req_unit.md
Name: store_req_unit

Overview:
- Issue side of the data-memory port: turns one load/store micro-op from the execute stage into a request on the SRAM-like data bus.
- Handles address, byte strobes and lane-replicated write data.
- The memory stage consumes the returned read data; this block only tracks outstanding responses.
- Detects misaligned accesses and raises an address-error pulse instead of issuing.

Parameters:
- MAX_OUTSTANDING, 2, maximum issued-but-unanswered requests (addr_ok seen, data_ok not yet seen).
- CNT_W, 2, width of the outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- op_valid  input  1  micro-op offered by the execute stage.
- op_ready  output  1  block accepts the micro-op this cycle.
- op_is_store  input  1  1 = store, 0 = load.
- op_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
- op_addr  input  32  byte address.
- op_wdata  input  32  store data, right-aligned.
- data_req  output  1  bus request.
- data_wr  output  1  1 = write.
- data_size  output  2  copy of op_size.
- data_addr  output  32  byte address.
- data_wstrb  output  4  byte enables; 0000 for loads.
- data_wdata  output  32  lane-replicated store data.
- data_addr_ok  input  1  address phase accepted.
- data_data_ok  input  1  one response (read data or write ack) returned.
- ade  output  1  one-cycle misaligned-address pulse.
- ade_addr  output  32  faulting address; held until the next ade.
- busy  output  1  state REQ or outstanding count != 0.

Behaviour:
- Reset (asynchronous): state IDLE, count 0, ade 0, ade_addr 0, all data_* registers 0. data_req is 0 during and after reset.
- States: IDLE and REQ.
- op_ready = (state==IDLE) && (count < MAX_OUTSTANDING). It is combinational and does not depend on op_valid.
- Accept = op_valid && op_ready.
- Misaligned operand: half with addr[0]=1, or word with addr[1:0]!=0.
  - On accept the block stays IDLE and issues no bus request.
  - Next cycle ade=1 and ade_addr=op_addr. ade is 0 otherwise.
  - The op is consumed.
- Aligned accept: register the bus fields and go to REQ. data_req=1 from the next cycle.
- In REQ, data_req, data_wr, data_size, data_addr, data_wstrb and data_wdata hold stable until data_addr_ok=1.
- When data_addr_ok=1 in REQ: go to IDLE, count+1. data_req=0 next cycle.
- Minimum issue spacing is one request per 2 cycles.
- data_addr_ok while IDLE is ignored.
- Strobes, with a = addr[1:0]:
  - byte: 4'b0001<<a
  - half: 4'b0011<<a
  - word: 4'b1111
  - load: 4'b0000
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata unchanged
  - load: 0
- Counter update:
  - data_data_ok alone: count-1.
  - addr_ok and data_ok in the same cycle: count unchanged.
  - data_data_ok while count==0: ignored, count saturates at 0.
- Backpressure: at count==MAX_OUTSTANDING, op_ready=0 until a data_ok arrives. Acceptance can resume in the cycle after that data_ok.
- No flush input. A request once on the bus is always completed. Squashing responses is the memory stage's responsibility.

Decomposition:
- Shared header (the team's global include), constants only:
  - MEM_SIZE_B=2'b00, MEM_SIZE_H=2'b01, MEM_SIZE_W=2'b10.
  - Outstanding-depth default.
- One natural combinational sub-module: store_lane_gen (op_size, addr[1:0], wdata, is_store → wstrb, wdata_rep, misalign).
- FSM and counter stay in the top module.

Test Plan:
- sb, addr=0x1000_0003, wdata=0x0000_00A5, addr_ok same cycle as data_req → data_req for exactly 1 cycle, wstrb=1000, wdata=0xA5A5A5A5, data_wr=1.
- sh, addr=0x2002, wdata=0x1234, addr_ok delayed 3 cycles → req and fields stable for 4 cycles, wstrb=1100, wdata=0x12341234, op_ready=0 throughout.
- lw, addr=0x3001 → no data_req, ade=1 for 1 cycle, ade_addr=0x3001, op_ready returns to 1 the next cycle.
- 3 back-to-back aligned stores, no data_ok → third held off, op_ready=0 at count=2. One data_ok → count=1 and third accepted the next cycle.
- addr_ok and data_ok in the same cycle at count=1 → count stays 1.
- Spurious data_ok at count=0 → count stays 0.
- Assert reset asynchronously while data_req=1 in REQ → data_req, ade and busy drop immediately without a clock. After release, op_ready=1.
